// File: rtl/synth_pkg.sv
// Shared encodings and widths for the voice allocator and its selector.
package synth_pkg;

    localparam int unsigned NOTE_W = 7;
    localparam int unsigned VEL_W  = 7;

    typedef enum logic [1:0] {
        SLOT_FREE     = 2'd0,
        SLOT_HELD     = 2'd1,
        SLOT_RELEASED = 2'd2
    } slot_state_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_STEAL_OFF = 2'd1,
        ST_ASSIGN    = 2'd2
    } fsm_state_t;

    typedef struct packed {
        logic [NOTE_W-1:0] note;
        logic [VEL_W-1:0]  velocity;
    } note_evt_t;

    // Index width for a voice count, never below one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/voice_select.sv
// Combinational voice picker: lowest free, else oldest released, else oldest held (steal).
module voice_select
    import synth_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned AGE_BITS   = 8,
    parameter int unsigned IDX_W      = 2
) (
    input  slot_state_t         slot_i [NUM_VOICES],
    input  logic [AGE_BITS-1:0] age_i  [NUM_VOICES],
    output logic [IDX_W-1:0]    target_idx_c,
    output logic                steal_c
);

    logic                have_free;
    logic                have_rel;
    logic                have_held;
    logic [IDX_W-1:0]    free_idx;
    logic [IDX_W-1:0]    rel_idx;
    logic [IDX_W-1:0]    held_idx;
    logic [AGE_BITS-1:0] rel_age;
    logic [AGE_BITS-1:0] held_age;

    // Strict '>' while scanning upward keeps age ties on the lowest index.
    always_comb begin
        have_free = 1'b0;
        have_rel  = 1'b0;
        have_held = 1'b0;
        free_idx  = '0;
        rel_idx   = '0;
        held_idx  = '0;
        rel_age   = '0;
        held_age  = '0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            if (slot_i[i] == SLOT_FREE && !have_free) begin
                have_free = 1'b1;
                free_idx  = IDX_W'(i);
            end
            if (slot_i[i] == SLOT_RELEASED && (!have_rel || age_i[i] > rel_age)) begin
                have_rel = 1'b1;
                rel_idx  = IDX_W'(i);
                rel_age  = age_i[i];
            end
            if (slot_i[i] == SLOT_HELD && (!have_held || age_i[i] > held_age)) begin
                have_held = 1'b1;
                held_idx  = IDX_W'(i);
                held_age  = age_i[i];
            end
        end

        target_idx_c = held_idx;
        steal_c      = have_held;
        if (have_free) begin
            target_idx_c = free_idx;
            steal_c      = 1'b0;
        end else if (have_rel) begin
            target_idx_c = rel_idx;
            steal_c      = 1'b0;
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic MIDI voice allocator: maps note events onto NUM_VOICES voice slots with stealing.
module voice_allocator
    import synth_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned AGE_BITS   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         midi_valid,
    output logic                         midi_ready,
    input  logic                         midi_note_on,
    input  logic [NOTE_W-1:0]            midi_note,
    input  logic [VEL_W-1:0]             midi_velocity,
    input  logic                         all_notes_off,
    output logic [NUM_VOICES-1:0]        voice_note_on,
    output logic [NUM_VOICES-1:0]        voice_note_off,
    output logic [NOTE_W*NUM_VOICES-1:0] voice_note,
    output logic [VEL_W*NUM_VOICES-1:0]  voice_velocity,
    output logic [NUM_VOICES-1:0]        voice_active
);

    localparam int unsigned         IDX_W   = idx_width(NUM_VOICES);
    localparam logic [AGE_BITS-1:0] AGE_MAX = '1;

    fsm_state_t                   state_q, state_d;
    slot_state_t                  slot_q [NUM_VOICES];
    slot_state_t                  slot_d [NUM_VOICES];
    logic [AGE_BITS-1:0]          age_q  [NUM_VOICES];
    logic [AGE_BITS-1:0]          age_d  [NUM_VOICES];
    logic [NOTE_W*NUM_VOICES-1:0] note_q, note_d;
    logic [VEL_W*NUM_VOICES-1:0]  vel_q, vel_d;
    logic [NUM_VOICES-1:0]        on_q, on_d;
    logic [NUM_VOICES-1:0]        off_q, off_d;
    logic [NUM_VOICES-1:0]        active_q, active_d;
    logic                         ready_q, ready_d;
    logic [IDX_W-1:0]             pend_idx_q, pend_idx_d;
    note_evt_t                    pend_evt_q, pend_evt_d;

    logic                         accept;
    logic                         is_on;
    logic [NUM_VOICES-1:0]        held_match;
    logic [IDX_W-1:0]             sel_idx_c;
    logic                         sel_steal_c;
    logic                         do_assign;
    logic [IDX_W-1:0]             asg_idx;
    note_evt_t                    asg_evt;
    logic                         retrig_done;

    voice_select #(
        .NUM_VOICES (NUM_VOICES),
        .AGE_BITS   (AGE_BITS),
        .IDX_W      (IDX_W)
    ) u_select (
        .slot_i       (slot_q),
        .age_i        (age_q),
        .target_idx_c (sel_idx_c),
        .steal_c      (sel_steal_c)
    );

    // The panic input gates readiness in the same cycle it is raised.
    assign midi_ready = ready_q & ~all_notes_off;
    assign accept     = midi_valid & midi_ready;
    assign is_on      = midi_note_on && (midi_velocity != '0);

    always_comb begin
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            held_match[i] = (slot_q[i] == SLOT_HELD) &&
                            (note_q[i*NOTE_W +: NOTE_W] == midi_note);
        end
    end

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        age_d       = age_q;
        note_d      = note_q;
        vel_d       = vel_q;
        on_d        = '0;
        off_d       = '0;
        pend_idx_d  = pend_idx_q;
        pend_evt_d  = pend_evt_q;
        do_assign   = 1'b0;
        asg_idx     = '0;
        asg_evt     = '0;
        retrig_done = 1'b0;

        if (all_notes_off) begin
            state_d = ST_IDLE;
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                if (slot_q[i] == SLOT_HELD) begin
                    slot_d[i] = SLOT_RELEASED;
                    off_d[i]  = 1'b1;
                end
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (!is_on) begin
                            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                                if (held_match[i]) begin
                                    slot_d[i] = SLOT_RELEASED;
                                    off_d[i]  = 1'b1;
                                end
                            end
                        end else if (|held_match) begin
                            // Retrigger touches only the matching voice; ages stay put.
                            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                                if (held_match[i] && !retrig_done) begin
                                    vel_d[i*VEL_W +: VEL_W] = midi_velocity;
                                    on_d[i]                 = 1'b1;
                                    retrig_done             = 1'b1;
                                end
                            end
                        end else if (sel_steal_c) begin
                            off_d[sel_idx_c]  = 1'b1;
                            slot_d[sel_idx_c] = SLOT_RELEASED;
                            pend_idx_d        = sel_idx_c;
                            pend_evt_d        = '{note: midi_note, velocity: midi_velocity};
                            state_d           = ST_STEAL_OFF;
                        end else begin
                            do_assign = 1'b1;
                            asg_idx   = sel_idx_c;
                            asg_evt   = '{note: midi_note, velocity: midi_velocity};
                            state_d   = ST_ASSIGN;
                        end
                    end
                end
                ST_STEAL_OFF: begin
                    do_assign = 1'b1;
                    asg_idx   = pend_idx_q;
                    asg_evt   = pend_evt_q;
                    state_d   = ST_ASSIGN;
                end
                ST_ASSIGN: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Assignment clears the target's age and ages everyone else.
        if (do_assign) begin
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                if (IDX_W'(i) == asg_idx) begin
                    slot_d[i]                 = SLOT_HELD;
                    note_d[i*NOTE_W +: NOTE_W] = asg_evt.note;
                    vel_d[i*VEL_W +: VEL_W]   = asg_evt.velocity;
                    age_d[i]                  = '0;
                    on_d[i]                   = 1'b1;
                end else if (age_q[i] != AGE_MAX) begin
                    age_d[i] = age_q[i] + AGE_BITS'(1);
                end
            end
        end

        ready_d = (state_d == ST_IDLE);
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            active_d[i] = (slot_d[i] == SLOT_HELD);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            note_q     <= '0;
            vel_q      <= '0;
            on_q       <= '0;
            off_q      <= '0;
            active_q   <= '0;
            ready_q    <= 1'b0;
            pend_idx_q <= '0;
            pend_evt_q <= '0;
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                slot_q[i] <= SLOT_FREE;
                age_q[i]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            note_q     <= note_d;
            vel_q      <= vel_d;
            on_q       <= on_d;
            off_q      <= off_d;
            active_q   <= active_d;
            ready_q    <= ready_d;
            pend_idx_q <= pend_idx_d;
            pend_evt_q <= pend_evt_d;
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                slot_q[i] <= slot_d[i];
                age_q[i]  <= age_d[i];
            end
        end
    end

    assign voice_note_on  = on_q;
    assign voice_note_off = off_q;
    assign voice_note     = note_q;
    assign voice_velocity = vel_q;
    assign voice_active   = active_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed self-checking bench for voice_allocator with NUM_VOICES=4.
module tb_voice_allocator;

    logic        clk;
    logic        rst;
    logic        midi_valid;
    logic        midi_ready;
    logic        midi_note_on;
    logic [6:0]  midi_note;
    logic [6:0]  midi_velocity;
    logic        all_notes_off;
    logic [3:0]  voice_note_on;
    logic [3:0]  voice_note_off;
    logic [27:0] voice_note;
    logic [27:0] voice_velocity;
    logic [3:0]  voice_active;

    int checks   = 0;
    int failures = 0;

    voice_allocator #(
        .NUM_VOICES (4),
        .AGE_BITS   (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .midi_valid     (midi_valid),
        .midi_ready     (midi_ready),
        .midi_note_on   (midi_note_on),
        .midi_note      (midi_note),
        .midi_velocity  (midi_velocity),
        .all_notes_off  (all_notes_off),
        .voice_note_on  (voice_note_on),
        .voice_note_off (voice_note_off),
        .voice_note     (voice_note),
        .voice_velocity (voice_velocity),
        .voice_active   (voice_active)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    // Pulse exclusivity holds on every cycle.
    always @(negedge clk) begin
        if (rst) begin
            checks++;
            if (!$onehot0(voice_note_on) || ((voice_note_on & voice_note_off) != 4'b0000)) begin
                failures++;
                $display("FAIL pulse_exclusive on=%b off=%b required onehot0 and disjoint",
                         voice_note_on, voice_note_off);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst           = 1'b0;
        midi_valid    = 1'b0;
        midi_note_on  = 1'b0;
        midi_note     = '0;
        midi_velocity = '0;
        all_notes_off = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(1);
    endtask

    // Wait (bounded) for ready, present one event, return #1 after the accepting edge.
    task automatic send(input logic on, input logic [6:0] note, input logic [6:0] vel);
        int k;
        k = 0;
        while (!midi_ready && k < 10) begin
            tick(1);
            k++;
        end
        checks++;
        if (midi_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_ready_wait note=%0d ready=%b required 1", note, midi_ready);
        end
        midi_valid    = 1'b1;
        midi_note_on  = on;
        midi_note     = note;
        midi_velocity = vel;
        tick(1);
        midi_valid    = 1'b0;
        midi_note_on  = 1'b0;
        midi_note     = '0;
        midi_velocity = '0;
    endtask

    task automatic fill4();
        send(1'b1, 7'd60, 7'd100);
        send(1'b1, 7'd62, 7'd100);
        send(1'b1, 7'd64, 7'd100);
        send(1'b1, 7'd66, 7'd100);
    endtask

    task automatic test_reset();
        rst           = 1'b0;
        midi_valid    = 1'b0;
        midi_note_on  = 1'b0;
        midi_note     = '0;
        midi_velocity = '0;
        all_notes_off = 1'b0;
        tick(2);
        checks++;
        if (midi_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready got=%b required 0", midi_ready);
        end
        checks++;
        if ({voice_note_on, voice_note_off, voice_active} !== 12'h000) begin
            failures++;
            $display("FAIL reset_pulses got on=%b off=%b act=%b required 0",
                     voice_note_on, voice_note_off, voice_active);
        end
        checks++;
        if ({voice_note, voice_velocity} !== 56'h0) begin
            failures++;
            $display("FAIL reset_data got note=%h vel=%h required 0", voice_note, voice_velocity);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (midi_ready !== 1'b0) begin
            failures++;
            $display("FAIL ready_before_edge got=%b required 0", midi_ready);
        end
        tick(1);
        checks++;
        if (midi_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_edge got=%b required 1", midi_ready);
        end
    endtask

    task automatic test_basic_note_on();
        do_reset();
        send(1'b1, 7'd60, 7'd100);
        checks++;
        if (voice_note_on !== 4'b0001 || voice_note_off !== 4'b0000) begin
            failures++;
            $display("FAIL basic_pulse on=%b off=%b required 0001/0000", voice_note_on, voice_note_off);
        end
        checks++;
        if (voice_note[6:0] !== 7'd60 || voice_velocity[6:0] !== 7'd100) begin
            failures++;
            $display("FAIL basic_data note=%0d vel=%0d required 60/100", voice_note[6:0], voice_velocity[6:0]);
        end
        checks++;
        if (voice_active !== 4'b0001 || midi_ready !== 1'b0) begin
            failures++;
            $display("FAIL basic_active act=%b ready=%b required 0001/0", voice_active, midi_ready);
        end
        tick(1);
        checks++;
        if (voice_note_on !== 4'b0000 || midi_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_after on=%b ready=%b required 0000/1", voice_note_on, midi_ready);
        end
    endtask

    task automatic test_steal();
        do_reset();
        fill4();
        send(1'b1, 7'd67, 7'd80);
        checks++;
        if (voice_note_off !== 4'b0001 || voice_note_on !== 4'b0000 || midi_ready !== 1'b0) begin
            failures++;
            $display("FAIL steal_off off=%b on=%b ready=%b required 0001/0000/0",
                     voice_note_off, voice_note_on, midi_ready);
        end
        tick(1);
        checks++;
        if (voice_note_on !== 4'b0001 || voice_note_off !== 4'b0000 || midi_ready !== 1'b0) begin
            failures++;
            $display("FAIL steal_on on=%b off=%b ready=%b required 0001/0000/0",
                     voice_note_on, voice_note_off, midi_ready);
        end
        checks++;
        if (voice_note[6:0] !== 7'd67 || voice_note[13:7] !== 7'd62 || voice_active !== 4'b1111) begin
            failures++;
            $display("FAIL steal_data n0=%0d n1=%0d act=%b required 67/62/1111",
                     voice_note[6:0], voice_note[13:7], voice_active);
        end
        tick(1);
        checks++;
        if (midi_ready !== 1'b1 || voice_note_on !== 4'b0000) begin
            failures++;
            $display("FAIL steal_done ready=%b on=%b required 1/0000", midi_ready, voice_note_on);
        end
        // Voice 1 is now the oldest held voice.
        send(1'b1, 7'd68, 7'd80);
        checks++;
        if (voice_note_off !== 4'b0010) begin
            failures++;
            $display("FAIL steal2_off off=%b required 0010", voice_note_off);
        end
        tick(1);
        checks++;
        if (voice_note_on !== 4'b0010 || voice_note[13:7] !== 7'd68) begin
            failures++;
            $display("FAIL steal2_on on=%b n1=%0d required 0010/68", voice_note_on, voice_note[13:7]);
        end
    endtask

    task automatic test_free_over_released();
        do_reset();
        send(1'b1, 7'd60, 7'd100);
        send(1'b1, 7'd62, 7'd100);
        send(1'b0, 7'd60, 7'd0);
        checks++;
        if (voice_note_off !== 4'b0001 || voice_active !== 4'b0010 || midi_ready !== 1'b1) begin
            failures++;
            $display("FAIL noteoff off=%b act=%b ready=%b required 0001/0010/1",
                     voice_note_off, voice_active, midi_ready);
        end
        checks++;
        if (voice_note[6:0] !== 7'd60) begin
            failures++;
            $display("FAIL release_hold n0=%0d required 60", voice_note[6:0]);
        end
        send(1'b1, 7'd70, 7'd100);
        checks++;
        if (voice_note_on !== 4'b0100 || voice_note[20:14] !== 7'd70) begin
            failures++;
            $display("FAIL free_pref on=%b n2=%0d required 0100/70", voice_note_on, voice_note[20:14]);
        end
        send(1'b1, 7'd72, 7'd100);
        checks++;
        if (voice_note_on !== 4'b1000) begin
            failures++;
            $display("FAIL fill_v3 on=%b required 1000", voice_note_on);
        end
        send(1'b1, 7'd74, 7'd100);
        checks++;
        if (voice_note_on !== 4'b0001 || voice_note_off !== 4'b0000 || voice_note[6:0] !== 7'd74) begin
            failures++;
            $display("FAIL reuse_released on=%b off=%b n0=%0d required 0001/0000/74",
                     voice_note_on, voice_note_off, voice_note[6:0]);
        end
    endtask

    task automatic test_retrigger();
        do_reset();
        send(1'b1, 7'd60, 7'd50);
        send(1'b1, 7'd60, 7'd90);
        checks++;
        if (voice_note_on !== 4'b0001 || voice_note_off !== 4'b0000) begin
            failures++;
            $display("FAIL retrig_pulse on=%b off=%b required 0001/0000", voice_note_on, voice_note_off);
        end
        checks++;
        if (voice_velocity[6:0] !== 7'd90 || voice_active !== 4'b0001 || voice_note[13:7] !== 7'd0) begin
            failures++;
            $display("FAIL retrig_data vel0=%0d act=%b n1=%0d required 90/0001/0",
                     voice_velocity[6:0], voice_active, voice_note[13:7]);
        end
    endtask

    task automatic test_panic();
        do_reset();
        send(1'b1, 7'd60, 7'd100);
        send(1'b1, 7'd62, 7'd100);
        send(1'b1, 7'd64, 7'd100);
        tick(1);
        all_notes_off = 1'b1;
        #1;
        checks++;
        if (midi_ready !== 1'b0) begin
            failures++;
            $display("FAIL panic_ready got=%b required 0", midi_ready);
        end
        tick(1);
        all_notes_off = 1'b0;
        checks++;
        if (voice_note_off !== 4'b0111 || voice_active !== 4'b0000 || voice_note_on !== 4'b0000) begin
            failures++;
            $display("FAIL panic_off off=%b act=%b on=%b required 0111/0000/0000",
                     voice_note_off, voice_active, voice_note_on);
        end
        tick(1);
        checks++;
        if (voice_note_off !== 4'b0000) begin
            failures++;
            $display("FAIL panic_single off=%b required 0000", voice_note_off);
        end
        send(1'b1, 7'd80, 7'd0);
        checks++;
        if (voice_note_on !== 4'b0000 || voice_note_off !== 4'b0000 || midi_ready !== 1'b1) begin
            failures++;
            $display("FAIL vel0_unheld on=%b off=%b ready=%b required 0000/0000/1",
                     voice_note_on, voice_note_off, midi_ready);
        end
    endtask

    task automatic test_abort_steal();
        do_reset();
        fill4();
        send(1'b1, 7'd67, 7'd80);
        all_notes_off = 1'b1;
        tick(1);
        all_notes_off = 1'b0;
        checks++;
        if (voice_note_on !== 4'b0000 || voice_note_off !== 4'b1110 || voice_active !== 4'b0000) begin
            failures++;
            $display("FAIL abort_steal on=%b off=%b act=%b required 0000/1110/0000",
                     voice_note_on, voice_note_off, voice_active);
        end
        tick(1);
        checks++;
        if (voice_note_on !== 4'b0000 || midi_ready !== 1'b1 || voice_note[6:0] !== 7'd60) begin
            failures++;
            $display("FAIL abort_drop on=%b ready=%b n0=%0d required 0000/1/60",
                     voice_note_on, midi_ready, voice_note[6:0]);
        end
    endtask

    task automatic test_reset_mid_steal();
        do_reset();
        fill4();
        send(1'b1, 7'd67, 7'd80);
        rst = 1'b0;
        #1;
        checks++;
        if ({voice_note_on, voice_note_off, voice_active} !== 12'h000 ||
            {voice_note, voice_velocity} !== 56'h0 || midi_ready !== 1'b0) begin
            failures++;
            $display("FAIL midreset_clear on=%b off=%b act=%b ready=%b required all 0",
                     voice_note_on, voice_note_off, voice_active, midi_ready);
        end
        tick(1);
        rst = 1'b1;
        #1;
        checks++;
        if (midi_ready !== 1'b0 || voice_note_on !== 4'b0000) begin
            failures++;
            $display("FAIL midreset_release ready=%b on=%b required 0/0000", midi_ready, voice_note_on);
        end
        tick(1);
        checks++;
        if (midi_ready !== 1'b1 || voice_note_on !== 4'b0000 || voice_note_off !== 4'b0000 ||
            voice_active !== 4'b0000) begin
            failures++;
            $display("FAIL midreset_after ready=%b on=%b off=%b act=%b required 1/0000/0000/0000",
                     midi_ready, voice_note_on, voice_note_off, voice_active);
        end
        tick(1);
        checks++;
        if (voice_note_on !== 4'b0000 || voice_note[6:0] !== 7'd0) begin
            failures++;
            $display("FAIL midreset_no_pulse on=%b n0=%0d required 0000/0", voice_note_on, voice_note[6:0]);
        end
    endtask

    initial begin
        test_reset();
        test_basic_note_on();
        test_steal();
        test_free_over_released();
        test_retrigger();
        test_panic();
        test_abort_steal();
        test_reset_mid_steal();
        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 Parameter NUM_VOICES, default 4, number of VOICE instances served (2..8).
REQ-002 Parameter AGE_BITS, default 8, width of per-voice saturating age counter.
REQ-003 clk  input  1  system clock; single clock domain.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 midi_valid  input  1  MIDI note event present.
REQ-006 midi_ready  output  1  allocator accepts event this cycle.
REQ-007 midi_note_on  input  1  1 = note-on, 0 = note-off.
REQ-008 midi_note  input  7  MIDI note number.
REQ-009 midi_velocity  input  7  MIDI velocity.
REQ-010 all_notes_off  input  1  single-cycle panic pulse (CC123).
REQ-011 voice_note_on  output  NUM_VOICES  one-cycle note_on pulse per voice.
REQ-012 voice_note_off  output  NUM_VOICES  one-cycle note_off pulse per voice.
REQ-013 voice_note  output  7*NUM_VOICES  held note_freq per voice; voice i at bits [7i+6:7i].
REQ-014 voice_velocity  output  7*NUM_VOICES  held velocity per voice, same packing.
REQ-015 voice_active  output  NUM_VOICES  1 while the voice slot is HELD.

Function
REQ-016 The block SHALL keep a per-voice slot state: FREE, HELD or RELEASED. It SHALL also keep a stored note, a stored velocity and an age counter for each voice.
REQ-017 The control FSM SHALL have the states IDLE, STEAL_OFF and ASSIGN.
REQ-018 midi_ready SHALL be 1 only in IDLE with all_notes_off low. An event SHALL be accepted only on a cycle where midi_valid and midi_ready are both 1.
REQ-019 A note-on with velocity 0 SHALL be treated as a note-off.
REQ-020 Note-on, retrigger: if a HELD voice already stores midi_note, the block SHALL update that voice's velocity and pulse its voice_note_on 1 cycle after acceptance. No other voice SHALL change.
REQ-021 Note-on, target selection SHALL follow this order:
  - the lowest-index FREE voice;
  - otherwise the oldest RELEASED voice;
  - otherwise the oldest HELD voice, which is stolen.
  Ties on age SHALL go to the lowest index.
REQ-022 Non-steal note-on: the FSM SHALL go IDLE->ASSIGN->IDLE. In ASSIGN the block SHALL load note and velocity, set the slot to HELD and pulse voice_note_on. The pulse SHALL appear 1 cycle after acceptance.
REQ-023 Steal note-on: the FSM SHALL go IDLE->STEAL_OFF->ASSIGN->IDLE. In STEAL_OFF the block SHALL pulse voice_note_off on the victim. voice_note_on SHALL follow 1 cycle later. Steal latency is 2 cycles.
REQ-024 On every assignment, the assigned voice's age SHALL be cleared to 0. Every other voice's age SHALL increment, saturating at 2^AGE_BITS-1.
REQ-025 Note-off: every HELD voice storing midi_note SHALL go to RELEASED and pulse voice_note_off 1 cycle after acceptance. The FSM SHALL stay in IDLE.
REQ-026 A note-off that matches no HELD voice SHALL be accepted and ignored.
REQ-027 all_notes_off SHALL pulse voice_note_off on all HELD voices on the next cycle and set those voices to RELEASED.
REQ-028 all_notes_off SHALL abort any STEAL_OFF or ASSIGN in progress, return the FSM to IDLE and drop the pending note-on.
REQ-029 voice_note and voice_velocity SHALL keep their values across release so that envelope release uses the last note.
REQ-030 At most one voice_note_on bit SHALL be high in any cycle.
REQ-031 No voice SHALL receive voice_note_on and voice_note_off in the same cycle.

Reset
REQ-032 While rst=0, the block SHALL hold:
  - all slots FREE and all ages 0;
  - the FSM in IDLE;
  - midi_ready=0;
  - voice_note_on, voice_note_off and voice_active at 0;
  - voice_note and voice_velocity at 0.
REQ-033 An assertion of rst in the middle of an operation SHALL discard the pending event and emit no further pulses.
REQ-034 midi_ready SHALL rise on the first clk edge after rst deasserts.

Structure
REQ-035 A shared package synth_pkg SHALL hold:
  - the slot-state encoding (FREE/HELD/RELEASED);
  - the FSM state encoding;
  - NOTE_W=7 and VEL_W=7.
REQ-036 A sub-module voice_select SHALL be combinational. It SHALL take slot states and ages and return the target index and a steal flag.
REQ-037 voice_allocator SHALL contain all registers.
REQ-038 Each voice_allocator output slice SHALL connect directly to the note_on, note_off, note_freq and velocity ports of one VOICE instance.

Verification
REQ-039 Reset, then note-on 60/vel 100 -> voice_note_on[0] pulses at acceptance+1, voice_note[0]=60, voice_active=0001.
REQ-040 Note-ons 60,62,64,66 then 67 (NUM_VOICES=4) -> voice_note_off[0] at +1, voice_note_on[0] at +2, voice_note[0]=67, midi_ready low for 2 cycles.
REQ-041 Note-on 60, note-on 62, note-off 60, note-on 70 -> voice 2 gets 70 (FREE preferred over RELEASED). Then fill voices 2-3 -> the next new note reuses voice 0 (RELEASED).
REQ-042 Note-on 60 vel 50, then note-on 60 vel 90 -> only voice 0 retriggers, voice_velocity[0]=90, voice_active=0001.
REQ-043 Three voices HELD, then all_notes_off -> voice_note_off=0111 for one cycle, voice_active=0000. Note-on vel 0 on an unheld note -> no pulses.
REQ-044 Start a steal, then pull rst low during STEAL_OFF -> no voice_note_on pulse, all outputs 0, midi_ready=1 one cycle after release.
